pipe_skid_reg: RTL and testbench

// - Elastic pipeline-stage register with valid/ready handshake on both sides:
//   the consuming end of one stage and the producing end of the next.
// - Decouples upstream ready from downstream ready using a 2-entry main+skid buffer.
// - Full throughput of 1 transfer/cycle, in-order delivery.
// - Sits between CPU pipeline stages (IF/ID, ID/EX, ...); used where a stage can stall.

---
 rtl/pipe_skid_reg_pkg.sv | 19 +
 rtl/pipe_skid_ctrl.sv | 77 +++++++
 rtl/pipe_skid_reg.sv | 53 +++++
 tb/tb_pipe_skid_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic main+skid pipeline register.
// State encodings are {main_valid, skid_valid}.
package pipe_skid_reg_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_SKID  = 2'b01,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    typedef enum logic {
        SEL_IN   = 1'b0,
        SEL_SKID = 1'b1
    } msel_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control FSM for pipe_skid_reg: valid flops, load enables and main mux select.
// The state register is the pair of valid flags, so ready/valid come straight from flops.
module pipe_skid_ctrl
    import pipe_skid_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic main_sel
);

    state_e r_state;
    state_e w_next;
    logic   w_in_fire;
    logic   w_out_fire;

    assign in_ready   = ~r_state[0];
    assign out_valid  = r_state[1];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_in_fire) w_next = ST_BUSY;
                ST_BUSY: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_next = ST_FULL;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_next = ST_EMPTY;
                    end
                end
                ST_FULL: if (w_out_fire) w_next = ST_BUSY;
                ST_SKID: w_next = ST_EMPTY;
            endcase
        end
    end

    // A flush suppresses all loads; the data regs simply keep their old contents.
    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        main_sel  = SEL_IN;
        if (!flush) begin
            unique case (r_state)
                ST_EMPTY: load_main = w_in_fire;
                ST_BUSY: begin
                    load_main = w_in_fire & w_out_fire;
                    load_skid = w_in_fire & ~w_out_fire;
                end
                ST_FULL: begin
                    load_main = w_out_fire;
                    main_sel  = SEL_SKID;
                end
                ST_SKID: load_main = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: 2-entry main+skid buffer with valid/ready on both sides.
// Upstream ready depends only on the skid flop, never on downstream ready.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_mux;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_sel;

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_main (w_load_main),
        .load_skid (w_load_skid),
        .main_sel  (w_main_sel)
    );

    assign w_mux = (w_main_sel == SEL_SKID) ? r_skid : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) r_main <= w_mux;
            if (w_load_skid) r_skid <= in_data;
        end
    end

    assign out_data = r_main;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, async reset sequence,
// and a randomised valid/ready scoreboard run.
module tb_pipe_skid_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         eir;
        logic         eov;
        logic [W-1:0] eod;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic eir, input logic eov,
                       input logic [W-1:0] eod);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.eir = eir; v.eov = eov; v.eod = eod;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [W+1:0] act,
                         input logic [W+1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {rdy,vld,data}=%h expected %h", nm, act, exp);
        end
    endtask

    logic [W-1:0] q[$];
    logic         pv;
    logic         pr;
    logic [W-1:0] pd;
    logic [W-1:0] exp_d;

    task automatic score(input string tag);
        if (pv && !pr)
            check({tag, "_stable"}, {1'b0, out_valid, out_data}, {1'b0, 1'b1, pd});
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_dup: got output %h expected none", tag, out_data);
            end else begin
                exp_d = q.pop_front();
                check({tag, "_order"}, {2'b00, out_data}, {2'b00, exp_d});
            end
        end
        if (in_valid && in_ready) q.push_back(in_data);
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
    endtask

    initial begin
        // stream 1..8, one cycle latency
        add(1, 8'd1, 1, 0, 1, 0, 8'd0);
        for (int k = 1; k < 8; k++)
            add(1, 8'(k + 1), 1, 0, 1, 1, 8'(k));
        add(0, 8'd0, 1, 0, 1, 1, 8'd8);
        add(0, 8'd0, 1, 0, 1, 0, 8'd8);
        // stall: A,B fill to FULL; FULL with in_valid & out_ready takes skid only
        add(1, 8'h0A, 0, 0, 1, 0, 8'd8);
        add(1, 8'h0B, 0, 0, 1, 1, 8'h0A);
        add(1, 8'hEE, 0, 0, 0, 1, 8'h0A);
        add(1, 8'hEE, 1, 0, 0, 1, 8'h0A);
        add(0, 8'h00, 1, 0, 1, 1, 8'h0B);
        add(0, 8'h00, 0, 0, 1, 0, 8'h0B);
        // flush in FULL, then 0xC is next output
        add(1, 8'h01, 0, 0, 1, 0, 8'h0B);
        add(1, 8'h02, 0, 0, 1, 1, 8'h01);
        add(0, 8'h00, 0, 1, 0, 1, 8'h01);
        add(1, 8'h0C, 0, 0, 1, 0, 8'h01);
        add(0, 8'h00, 1, 0, 1, 1, 8'h0C);
        add(0, 8'h00, 1, 0, 1, 0, 8'h0C);
        // flush drops concurrent in_fire
        add(1, 8'h33, 1, 1, 1, 0, 8'h0C);
        add(0, 8'h00, 1, 0, 1, 0, 8'h0C);

        #12;
        check("reset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            #1;
            check($sformatf("vec%0d", i), {in_ready, out_valid, out_data},
                  {tbl[i].eir, tbl[i].eov, tbl[i].eod});
            @(negedge clk);
        end
        flush = 1'b0;

        // async reset while FULL
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_before_rst", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 8'h11});
        #2 rst = 1'b1;
        #1;
        check("async_rst", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ignores_in", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("after_rst", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});

        // random valid/ready against a FIFO scoreboard
        pv = 1'b0; pr = 1'b1; pd = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = W'($urandom);
            #1;
            score("rand");
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            score("drain");
            @(negedge clk);
        end
        n_vec++;
        if (q.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL drain_empty: got %0d pending, out_valid=%0b expected 0, 0",
                     q.size(), out_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
